// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory port, IF/ID pipeline register and
// decode-side control (stall / redirect) grouped in one bundle.
interface instruction_fetch_if #(
   parameter int COUNT_WIDTH = 16
);
   logic                   stall;
   logic                   branch_taken;
   logic [31:0]            branch_target;
   logic [31:0]            mem_address;
   logic [31:0]            instruction;
   logic [31:0]            if_id_pc;
   logic [31:0]            if_id_instruction;
   logic                   if_id_valid;
   logic                   done;
   logic                   misaligned;
   logic [COUNT_WIDTH-1:0] fetch_count;

   modport master (
      input  stall, branch_taken, branch_target, instruction,
      output mem_address, if_id_pc, if_id_instruction, if_id_valid,
             done, misaligned, fetch_count
   );

   modport slave (
      output stall, branch_taken, branch_target, instruction,
      input  mem_address, if_id_pc, if_id_instruction, if_id_valid,
             done, misaligned, fetch_count
   );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses the combinational instruction memory and
// fills the IF/ID register, with stall, redirect and end-of-program halt.
module instruction_fetch #(
   parameter int          NUM_INSTRUCTIONS = 13,
   parameter logic [31:0] RESET_PC         = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD         = 32'h0000_0013,
   parameter int          COUNT_WIDTH      = 16
) (
   input logic                 clock,
   input logic                 reset_n,
   instruction_fetch_if.master fetchBus
);

   localparam logic [31:0] END_ADDR = 32'(NUM_INSTRUCTIONS * 4);

   typedef enum logic {FETCH, DONE} fetchState_t;

   fetchState_t            state, stateNext;
   logic [31:0]            pc, pcNext;
   logic [31:0]            ifIdPc, ifIdPcNext;
   logic [31:0]            ifIdInstruction, ifIdInstructionNext;
   logic                   ifIdValid, ifIdValidNext;
   logic                   misalignedReg, misalignedNext;
   logic [COUNT_WIDTH-1:0] fetchCount, fetchCountNext;

   // State and pipeline register; everything returns to reset values at once.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= FETCH;
         pc              <= RESET_PC;
         ifIdPc          <= 32'h0;
         ifIdInstruction <= NOP_WORD;
         ifIdValid       <= 1'b0;
         misalignedReg   <= 1'b0;
         fetchCount      <= '0;
      end else begin
         state           <= stateNext;
         pc              <= pcNext;
         ifIdPc          <= ifIdPcNext;
         ifIdInstruction <= ifIdInstructionNext;
         ifIdValid       <= ifIdValidNext;
         misalignedReg   <= misalignedNext;
         fetchCount      <= fetchCountNext;
      end
   end

   // Redirect beats stall beats normal fetch; misaligned is a one-cycle pulse.
   always_comb begin
      stateNext           = state;
      pcNext              = pc;
      ifIdPcNext          = ifIdPc;
      ifIdInstructionNext = ifIdInstruction;
      ifIdValidNext       = ifIdValid;
      misalignedNext      = 1'b0;
      fetchCountNext      = fetchCount;

      if (fetchBus.branch_taken) begin
         pcNext              = {fetchBus.branch_target[31:2], 2'b00};
         ifIdPcNext          = pc;
         ifIdInstructionNext = NOP_WORD;
         ifIdValidNext       = 1'b0;
         misalignedNext      = |fetchBus.branch_target[1:0];
         stateNext           = FETCH;
      end else if (!fetchBus.stall) begin
         case (state)
            FETCH: begin
               if (pc < END_ADDR) begin
                  ifIdPcNext          = pc;
                  ifIdInstructionNext = fetchBus.instruction;
                  ifIdValidNext       = 1'b1;
                  pcNext              = pc + 32'd4;
                  if (fetchCount != {COUNT_WIDTH{1'b1}})
                     fetchCountNext = fetchCount + COUNT_WIDTH'(1);
               end else begin
                  ifIdInstructionNext = NOP_WORD;
                  ifIdValidNext       = 1'b0;
                  stateNext           = DONE;
               end
            end
            DONE: begin
               ifIdInstructionNext = NOP_WORD;
               ifIdValidNext       = 1'b0;
            end
            default: stateNext = FETCH;
         endcase
      end
   end

   assign fetchBus.mem_address       = pc;
   assign fetchBus.if_id_pc          = ifIdPc;
   assign fetchBus.if_id_instruction = ifIdInstruction;
   assign fetchBus.if_id_valid       = ifIdValid;
   assign fetchBus.done              = (state == DONE);
   assign fetchBus.misaligned        = misalignedReg;
   assign fetchBus.fetch_count       = fetchCount;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the single-clock datapath. Owns the program counter and drives the word address into the combinational instruction memory. Captures the returned word into the IF/ID pipeline register for decode. Supports decode-stage stalls and branch/jump redirects, and halts cleanly once the PC passes the last loaded instruction.

## Interface
Parameters:
- NUM_INSTRUCTIONS, 13: words loaded into instruction memory; END_ADDR = NUM_INSTRUCTIONS*4.
- RESET_PC, 32'h0000_0000: PC value after reset; must be word-aligned.
- NOP_WORD, 32'h0000_0013: word placed in if_id_instruction when the slot is squashed or empty.
- COUNT_WIDTH, 16: width of fetch_count.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  reset is asynchronous and active-low.
- stall  in  1  decode cannot accept; hold PC and IF/ID.
- branch_taken  in  1  redirect request from decode/execute.
- branch_target  in  32  redirect byte address; bits [1:0] ignored.
- mem_address  out  32  byte address to instruction memory; equals pc.
- instruction  in  32  word returned combinationally for mem_address.
- if_id_pc  out  32  PC of the captured instruction.
- if_id_instruction  out  32  captured instruction word.
- if_id_valid  out  1  IF/ID holds a real instruction.
- done  out  1  fetch has run past END_ADDR.
- misaligned  out  1  one-cycle pulse: last accepted redirect had target[1:0] != 0.
- fetch_count  out  COUNT_WIDTH  number of valid instructions latched into IF/ID; saturating.

## Operation
- States: FETCH, DONE. Reset enters FETCH.
- Priority each cycle: reset > branch_taken > stall > normal.
- Redirect (any state):
  - pc <= {branch_target[31:2],2'b00}.
  - if_id_valid <= 0 and if_id_instruction <= NOP_WORD, which squashes the wrong-path word.
  - if_id_pc <= pc.
  - misaligned <= |branch_target[1:0].
  - state <= FETCH.
  - A redirect during stall is still taken; stall is ignored that cycle.
- Stall in FETCH, no redirect: pc, IF/ID, fetch_count and state all hold.
- Normal FETCH with pc < END_ADDR:
  - if_id_pc <= pc, if_id_instruction <= instruction, if_id_valid <= 1.
  - pc <= pc + 4, with 32-bit wrap.
  - fetch_count <= fetch_count + 1, saturating at all ones.
- Normal FETCH with pc >= END_ADDR: if_id_valid <= 0, if_id_instruction <= NOP_WORD, state <= DONE. PC holds.
- DONE: PC and fetch_count hold. if_id_valid stays 0. Only a redirect leaves DONE.
- done = (state == DONE), decoded combinationally from the state register.
- mem_address = pc at all times. The memory is never addressed with a pc >= END_ADDR while a word is being captured.
- A redirect target >= END_ADDR enters FETCH, then moves to DONE on the next non-stalled cycle without capturing anything.

## Timing
- Reset values:
  - pc = RESET_PC; if_id_pc = 0; if_id_instruction = NOP_WORD.
  - if_id_valid = 0; misaligned = 0; fetch_count = 0; done = 0.
- Latency: the word at address A appears on if_id_instruction one edge after pc == A with no stall.
- Redirect penalty: one bubble. The target instruction is valid in IF/ID two edges after the redirect cycle.
- misaligned is high for exactly the one cycle after the redirect edge. It clears on the next edge unless another misaligned redirect occurs.
- Reset asserted mid-run clears all state asynchronously, without waiting for a clock edge. The first capture after deassertion is from RESET_PC.
- Sustained throughput is one instruction per cycle while stall is low.

## Test plan
- Reset, then 13 free-running cycles:
  - IF/ID shows pc 0x00..0x30 in order with valid=1.
  - Cycle 14 gives valid=0 and done=1; fetch_count=13.
- Stall held 3 cycles while pc=0x08: if_id_pc stays 0x04, pc stays 0x08, fetch_count stays unchanged.
- branch_taken with target 0x08 while pc=0x14:
  - Next IF/ID has valid=0 and instruction NOP_WORD.
  - The following IF/ID shows pc 0x08.
- branch_taken with target 0x0E: pc becomes 0x0C, misaligned pulses for one cycle, and IF/ID later shows pc 0x0C.
- branch_taken and stall together: redirect is taken, the bubble is inserted, and the stall is ignored. Then a redirect to 0x00 from DONE resumes fetch with done=0.
- reset_n pulsed low between clock edges mid-run: all outputs return to their reset values immediately, and fetch restarts at 0x00.
